// File: rtl/static_bridge.sv
// static_bridge: turns the scan-latched static command into a single access
// on the SIMD engine memory port, and returns read data and a completion level.
// Optional feature macro: STATIC_BRIDGE_TIMEOUT_EN adds a watchdog that ends a
// stalled access after TIMEOUT_CYCLES cycles, reporting 16'hDEAD for reads.
module static_bridge #(
    parameter int SYNC_STAGES    = 2,
    parameter int ADDR_W         = 11,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              static_wen,
    input  logic              static_ren,
    input  logic [15:0]       static_addr,
    input  logic [15:0]       static_wdata,
    output logic [15:0]       static_rdata,
    output logic              static_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_isel,
    output logic [3:0]        mem_lane,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [15:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RWAIT} state_t;

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] wen_sync, ren_sync;
    logic wen_prev, ren_prev;
    logic start_w, start_r, start;
    logic timeout;

    logic              mem_req_nx, mem_we_nx, mem_isel_nx, ready_nx;
    logic [3:0]        mem_lane_nx;
    logic [ADDR_W-1:0] mem_addr_nx;
    logic [15:0]       mem_wdata_nx, rdata_nx;

    // Strobe synchronisers plus previous-value flops for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_sync <= '0;
            ren_sync <= '0;
            wen_prev <= 1'b0;
            ren_prev <= 1'b0;
        end else begin
            wen_sync <= {wen_sync[SYNC_STAGES-2:0], static_wen};
            ren_sync <= {ren_sync[SYNC_STAGES-2:0], static_ren};
            wen_prev <= wen_sync[SYNC_STAGES-1];
            ren_prev <= ren_sync[SYNC_STAGES-1];
        end
    end

    // A write edge takes precedence; a coincident read edge simply folds into it
    assign start_w = wen_sync[SYNC_STAGES-1] & ~wen_prev;
    assign start_r = ren_sync[SYNC_STAGES-1] & ~ren_prev;
    assign start   = start_w | start_r;

`ifdef STATIC_BRIDGE_TIMEOUT_EN
    localparam int WD_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [WD_W-1:0] wdog;
    logic            busy;

    assign busy    = (state == REQ) || (state == RWAIT);
    assign timeout = busy && (wdog == WD_W'(TIMEOUT_CYCLES - 1));

    // Watchdog restarts on every entry into a busy state, counts while busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wdog <= '0;
        else if (state_nx != state && (state_nx == REQ || state_nx == RWAIT))
            wdog <= '0;
        else if (busy)
            wdog <= wdog + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    // State and registered outputs; reset abandons any in-flight access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_isel     <= 1'b0;
            mem_lane     <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            static_rdata <= '0;
            static_ready <= 1'b0;
        end else begin
            state        <= state_nx;
            mem_req      <= mem_req_nx;
            mem_we       <= mem_we_nx;
            mem_isel     <= mem_isel_nx;
            mem_lane     <= mem_lane_nx;
            mem_addr     <= mem_addr_nx;
            mem_wdata    <= mem_wdata_nx;
            static_rdata <= rdata_nx;
            static_ready <= ready_nx;
        end
    end

    // Next-state and output values; starts outside IDLE are dropped
    always_comb begin
        state_nx     = state;
        mem_req_nx   = mem_req;
        mem_we_nx    = mem_we;
        mem_isel_nx  = mem_isel;
        mem_lane_nx  = mem_lane;
        mem_addr_nx  = mem_addr;
        mem_wdata_nx = mem_wdata;
        rdata_nx     = static_rdata;
        ready_nx     = static_ready;
        case (state)
            IDLE: begin
                if (start) begin
                    mem_req_nx   = 1'b1;
                    mem_we_nx    = start_w;
                    mem_isel_nx  = static_addr[0];
                    mem_lane_nx  = static_addr[4:1];
                    mem_addr_nx  = static_addr[5 +: ADDR_W];
                    mem_wdata_nx = static_wdata;
                    ready_nx     = 1'b0;
                    state_nx     = REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    mem_req_nx = 1'b0;
                    if (mem_we) begin
                        ready_nx = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        state_nx = RWAIT;
                    end
                end else if (timeout) begin
                    mem_req_nx = 1'b0;
                    if (!mem_we) rdata_nx = 16'hDEAD;
                    ready_nx   = 1'b1;
                    state_nx   = IDLE;
                end
            end
            RWAIT: begin
                if (mem_rvalid) begin
                    rdata_nx = mem_rdata;
                    ready_nx = 1'b1;
                    state_nx = IDLE;
                end else if (timeout) begin
                    rdata_nx = 16'hDEAD;
                    ready_nx = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_static_bridge.sv
// tb_static_bridge: directed stimulus pushes expected memory accesses and
// completions into queues; a negedge monitor pops and compares them.
module tb_static_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        static_wen, static_ren;
    logic [15:0] static_addr, static_wdata, static_rdata;
    logic        static_ready;
    logic        mem_req, mem_we, mem_isel;
    logic [3:0]  mem_lane;
    logic [10:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [15:0] mem_rdata;

    typedef struct {
        logic        we;
        logic        isel;
        logic [3:0]  lane;
        logic [10:0] addr;
        logic [15:0] wdata;
    } acc_t;

    acc_t        acc_q[$];
    logic [15:0] rsp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic        rdy_prev = 1'b0;

    static_bridge #(.SYNC_STAGES(2), .ADDR_W(11), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .static_wen(static_wen), .static_ren(static_ren),
        .static_addr(static_addr), .static_wdata(static_wdata),
        .static_rdata(static_rdata), .static_ready(static_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_isel(mem_isel),
        .mem_lane(mem_lane), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_acc(input logic we, input logic isel, input logic [3:0] lane,
                           input logic [10:0] addr, input logic [15:0] wdata);
        acc_t a;
        a.we = we; a.isel = isel; a.lane = lane; a.addr = addr; a.wdata = wdata;
        acc_q.push_back(a);
    endtask

    // Monitor: every granted request and every ready rising edge is scored
    always @(negedge clk) begin
        if (rst) begin
            rdy_prev = 1'b0;
        end else begin
            if (mem_req && mem_gnt) begin
                checks++;
                if (acc_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_access: got we=%b addr=%h none expected", mem_we, mem_addr);
                end else begin
                    acc_t e;
                    e = acc_q.pop_front();
                    if (mem_we !== e.we || mem_isel !== e.isel || mem_lane !== e.lane ||
                        mem_addr !== e.addr || mem_wdata !== e.wdata) begin
                        errors++;
                        $display("FAIL access: got we=%b isel=%b lane=%h addr=%h wdata=%h expected we=%b isel=%b lane=%h addr=%h wdata=%h",
                                 mem_we, mem_isel, mem_lane, mem_addr, mem_wdata,
                                 e.we, e.isel, e.lane, e.addr, e.wdata);
                    end
                end
            end
            if (static_ready && !rdy_prev) begin
                checks++;
                if (rsp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ready: got rdata=%h none expected", static_rdata);
                end else begin
                    logic [15:0] r;
                    r = rsp_q.pop_front();
                    if (static_rdata !== r) begin
                        errors++;
                        $display("FAIL completion_rdata: got %h expected %h", static_rdata, r);
                    end
                end
            end
            rdy_prev = static_ready;
        end
    end

    initial begin
        rst = 1'b1; static_wen = 0; static_ren = 0; static_addr = 0; static_wdata = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        tick(2);
        chk("rst_mem_req", 16'(mem_req), 16'h0);
        chk("rst_ready", 16'(static_ready), 16'h0);
        chk("rst_rdata", static_rdata, 16'h0);
        chk("rst_mem_addr", 16'(mem_addr), 16'h0);
        rst = 1'b0;
        tick(2);

        // Write with grant in the first request cycle
        static_addr = 16'h0A5B; static_wdata = 16'h1234;
        exp_acc(1'b1, 1'b1, 4'hD, 11'h052, 16'h1234);
        rsp_q.push_back(16'h0000);
        static_wen = 1'b1;
        tick(2);
        chk("wr_latency_early", 16'(mem_req), 16'h0);
        tick(1);
        chk("wr_latency_req", 16'(mem_req), 16'h1);
        mem_gnt = 1'b1;
        tick(1);
        mem_gnt = 1'b0;
        chk("wr_req_drop", 16'(mem_req), 16'h0);
        chk("wr_ready", 16'(static_ready), 16'h1);
        static_wen = 1'b0;
        tick(4);

        // Read: grant after two wait cycles, rvalid three cycles later
        static_addr = 16'h0020;
        exp_acc(1'b0, 1'b0, 4'h0, 11'h001, 16'h1234);
        rsp_q.push_back(16'hBEEF);
        static_ren = 1'b1;
        tick(3);
        chk("rd_req_c1", 16'(mem_req), 16'h1);
        chk("rd_ready_clr", 16'(static_ready), 16'h0);
        tick(1);
        chk("rd_req_c2", 16'(mem_req), 16'h1);
        tick(1);
        chk("rd_req_c3", 16'(mem_req), 16'h1);
        mem_gnt = 1'b1;
        tick(1);
        mem_gnt = 1'b0;
        chk("rd_req_drop", 16'(mem_req), 16'h0);
        tick(2);
        chk("rd_wait_ready", 16'(static_ready), 16'h0);
        mem_rvalid = 1'b1; mem_rdata = 16'hBEEF;
        tick(1);
        mem_rvalid = 1'b0; mem_rdata = 16'h0;
        chk("rd_rdata", static_rdata, 16'hBEEF);
        chk("rd_ready", 16'(static_ready), 16'h1);
        static_ren = 1'b0;
        tick(4);

        // Simultaneous wen/ren: a single write, no read afterwards
        static_addr = 16'h1234; static_wdata = 16'h5555;
        exp_acc(1'b1, 1'b0, 4'hA, 11'h091, 16'h5555);
        rsp_q.push_back(16'hBEEF);
        static_wen = 1'b1; static_ren = 1'b1;
        tick(3);
        chk("both_we", 16'(mem_we), 16'h1);
        mem_gnt = 1'b1;
        tick(4);
        chk("both_no_second", 16'(mem_req), 16'h0);
        mem_gnt = 1'b0;
        static_wen = 1'b0; static_ren = 1'b0;
        tick(4);

        // Second start while waiting for read data is dropped
        static_addr = 16'h0041;
        exp_acc(1'b0, 1'b1, 4'h0, 11'h002, 16'h5555);
        rsp_q.push_back(16'hCAFE);
        static_ren = 1'b1;
        tick(3);
        mem_gnt = 1'b1;
        tick(1);
        mem_gnt = 1'b0;
        static_wen = 1'b1;
        tick(5);
        chk("drop_no_req", 16'(mem_req), 16'h0);
        chk("drop_ready", 16'(static_ready), 16'h0);
        mem_rvalid = 1'b1; mem_rdata = 16'hCAFE;
        tick(1);
        mem_rvalid = 1'b0;
        chk("drop_rdata", static_rdata, 16'hCAFE);
        tick(3);
        chk("drop_idle", 16'(mem_req), 16'h0);
        static_wen = 1'b0; static_ren = 1'b0;
        tick(4);

        // Reset while requesting: outputs clear without a clock edge
        static_addr = 16'h0000; static_wdata = 16'h0000;
        static_wen = 1'b1;
        tick(3);
        chk("rstreq_pre", 16'(mem_req), 16'h1);
        rst = 1'b1; static_wen = 1'b0;
        #1;
        chk("rstreq_req", 16'(mem_req), 16'h0);
        chk("rstreq_ready", 16'(static_ready), 16'h0);
        chk("rstreq_rdata", static_rdata, 16'h0);
        tick(1);
        rst = 1'b0;
        tick(2);

        // Command after reset behaves normally
        static_addr = 16'h07E0;
        exp_acc(1'b0, 1'b0, 4'h0, 11'h03F, 16'h0000);
        rsp_q.push_back(16'h1357);
        static_ren = 1'b1;
        tick(3);
        mem_gnt = 1'b1;
        tick(1);
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 16'h1357;
        tick(1);
        mem_rvalid = 1'b0;
        chk("post_rst_rdata", static_rdata, 16'h1357);
        chk("post_rst_ready", 16'(static_ready), 16'h1);
        static_ren = 1'b0;
        tick(4);

`ifdef STATIC_BRIDGE_TIMEOUT_EN
        // Read never granted: watchdog ends it after 8 request cycles
        static_addr = 16'h0100;
        rsp_q.push_back(16'hDEAD);
        static_ren = 1'b1;
        tick(3);
        chk("to_req", 16'(mem_req), 16'h1);
        tick(7);
        chk("to_req_last", 16'(mem_req), 16'h1);
        tick(1);
        chk("to_req_drop", 16'(mem_req), 16'h0);
        chk("to_rdata", static_rdata, 16'hDEAD);
        chk("to_ready", 16'(static_ready), 16'h1);
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'h4444;
        tick(2);
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        chk("to_late_ignored", static_rdata, 16'hDEAD);
        static_ren = 1'b0;
        tick(4);
`endif

        chk("acc_q_empty", 16'(acc_q.size()), 16'h0);
        chk("rsp_q_empty", 16'(rsp_q.size()), 16'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard bound on run time
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/static_bridge.md
Name: static_bridge

Overview:
- Sits directly downstream of the scan chain. Consumes the scan-latched static command (static_wen, static_ren, static_addr, static_wdata) and performs one access on the SIMD engine memory port per command.
- Returns static_rdata and static_ready, which the scan chain loads back on its next load-chain operation.
- The static inputs are quasi-static: they change only on scan load-chip and are asynchronous to clk. The bridge synchronises the strobes and samples the payload once those strobes are stable.

Parameters:
- SYNC_STAGES, 2, number of flops in each wen/ren synchroniser (minimum 2).
- ADDR_W, 11, word-address width on the memory port; equals static_addr[15:5].
- TIMEOUT_CYCLES, 255, watchdog limit used only when the optional feature is compiled in.

Ports:
- clk  input  1  core clock.
- rst  input  1  asynchronous reset, active-high.
- static_wen  input  1  write strobe from the scan latches (asynchronous).
- static_ren  input  1  read strobe from the scan latches (asynchronous).
- static_addr  input  16  bits [15:5] = word address, [4:1] = lane_id, [0] = i/d select (1 = instruction memory).
- static_wdata  input  16  write data.
- static_rdata  output  16  read data returned to the scan chain.
- static_ready  output  1  command complete; level signal.
- mem_req  output  1  memory request, held until granted.
- mem_we  output  1  1 = write, 0 = read.
- mem_isel  output  1  instruction/data memory select.
- mem_lane  output  4  target lane.
- mem_addr  output  ADDR_W  word address.
- mem_wdata  output  16  write data.
- mem_gnt  input  1  request accepted this cycle.
- mem_rvalid  input  1  read data valid; arrives 1 or more cycles after gnt.
- mem_rdata  input  16  read data.

Behaviour:
- Reset (asynchronous):
  - Synchronisers and previous-value flops cleared.
  - State = IDLE.
  - mem_req = 0, mem_we = 0, mem_isel = 0, mem_lane = 0, mem_addr = 0, mem_wdata = 0.
  - static_rdata = 0, static_ready = 0.
- Synchronisers: static_wen and static_ren each pass through a SYNC_STAGES flop chain. A start is the rising edge of a synchronised strobe (synced = 1, previous = 0). static_addr and static_wdata are not synchronised; they are sampled only on the start edge, when they are stable by protocol.
- Start latency: with SYNC_STAGES = 2, mem_req is high at the 3rd rising clk edge after static_wen or static_ren rises.
- States:
  - IDLE: on a start, capture the payload into mem_*, set mem_we = write, set mem_req = 1, clear static_ready, go to REQ.
  - REQ: mem_req held and all mem_* held stable.
    - On a write with mem_gnt: mem_req = 0, static_ready = 1, go to IDLE.
    - On a read with mem_gnt: mem_req = 0, go to RWAIT.
  - RWAIT: on mem_rvalid, static_rdata = mem_rdata, static_ready = 1, go to IDLE. mem_rvalid in any other state is ignored.
- Simultaneous wen and ren rising edges on the same cycle: write wins, read is discarded, only one access is issued.
- A start arriving while in REQ or RWAIT is dropped, not queued. Host software must poll static_ready before issuing the next command.
- Strobe falling while busy: no effect; the access completes.
- Completion outputs:
  - static_ready stays 1 until the next start.
  - static_rdata holds its value until the next read completes; writes leave it unchanged.
- Only one outstanding access at a time. Throughput is one command per scan round trip.
- Reset mid-operation drops mem_req immediately and abandons the in-flight access. No response is generated.

Optional Feature:
- Macro: STATIC_BRIDGE_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit-or-wider watchdog counter clears on entry to REQ or RWAIT and increments each cycle spent in those states.
  - On reaching TIMEOUT_CYCLES: mem_req = 0, static_rdata = 16'hDEAD (reads only; writes leave it unchanged), static_ready = 1, go to IDLE. Any later mem_rvalid or mem_gnt belonging to that access is ignored.
- Without the macro: no counter; the bridge waits indefinitely in REQ or RWAIT.

Test Plan:
- Write: static_addr = 16'h0A5B, wdata = 16'h1234, raise wen, gnt same cycle as req → one write with mem_addr = 11'h052, mem_lane = 4'hD, mem_isel = 1, mem_wdata = 16'h1234. static_ready rises the cycle after gnt.
- Read: addr = 16'h0020, raise ren, gnt after 2 cycles, rvalid with 16'hBEEF 3 cycles later → static_rdata = 16'hBEEF, static_ready = 1. mem_req is high for exactly 3 cycles.
- Simultaneous wen and ren rise → exactly one access with mem_we = 1; no read is issued.
- Second start while in RWAIT → dropped. Exactly one access is observed; ready behaviour is unchanged.
- Assert rst while in REQ → mem_req = 0 and static_ready = 0 immediately without a clock edge; the next command works normally.
- With STATIC_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES = 8: read with mem_gnt held 0 → after 8 cycles mem_req = 0, static_rdata = 16'hDEAD, static_ready = 1.
